freq_edge_counter: RTL
======================

// Module: freq_edge_counter
// PURPOSE
//  Measures the frequency of an asynchronous input by counting its rising edges over a fixed gate window.
//  Converts each window's count to two BCD digits (tens, units).
//  Presents the digits with a one-cycle load strobe to the downstream two-digit seven-segment driver.
//  Windows run back-to-back continuously; conversion works on a snapshot, so no edges are lost.
// PARAMETERS
//  UPDATE_PERIOD  1200  gate window length in clk cycles; legal range 32..65535
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  signal      in   1  asynchronous input whose frequency is measured
//  load        out  1  one-cycle strobe; ten_count/unit_count are valid while high
//  ten_count   out  4  BCD tens digit, 0..9
//  unit_count  out  4  BCD units digit, 0..9
//  overflow    out  1  only when FREQ_OVERFLOW_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: load=0, ten_count=0, unit_count=0, overflow=0.
//    Also at reset: state=COUNT, timer=0, edge count=0, synchroniser flops=0.
//  Input path:
//    - signal passes through a 2-flop synchroniser, then a registered rising-edge detector.
//    - The edge pulse appears 3 clk cycles after the pin rises.
//    - Maximum countable rate is clk/2.
//  Timer:
//    - Counts 0..UPDATE_PERIOD-1 and wraps; runs in every state.
//    - Cycle E is the window-end cycle, where timer==UPDATE_PERIOD-1.
//  Edge counter:
//    - Width EDGE_W=$clog2(UPDATE_PERIOD+1); increments on each edge pulse.
//    - At the end of cycle E it is cleared to 0, or to 1 if an edge pulse occurs in E+1... see next bullet.
//    - Exact rule: a pulse in cycle E belongs to the closing window. The counter restarts at 0 for cycle E+1.
//    - Snapshot: work <= (count_incl_E > 99) ? 99 : count_incl_E. Saturation is done before conversion.
//  FSM states:
//    COUNT: wait. If E, take the snapshot, clear tens accumulator, go to TENS.
//    TENS:
//      - If work>=10: work-=10, tens_acc+=1, stay in TENS.
//      - Else: ten_count<=tens_acc, unit_count<=work[3:0], go to LOAD.
//    LOAD: load=1 for exactly this cycle, then go to COUNT.
//  Latency: load is high in cycle E+T+2, where T is the tens digit (maximum E+11).
//    Because UPDATE_PERIOD>=32, conversion always finishes before the next E.
//  ten_count/unit_count:
//    - Registered; change only on the TENS->LOAD transition.
//    - Held stable until the next conversion.
//  A window with no edges produces digits 0/0 with a normal load pulse.
//  Reset asserted mid-window or mid-conversion aborts everything: reset values next cycle, no load pulse.
//    The window restarts when reset is released.
//  load and the edge counter are independent: edges arriving during TENS/LOAD count in the new window.
// CONFIGURATION
//  FREQ_OVERFLOW_EN defined:
//    - Adds output overflow, registered and updated in the same cycle as the digits.
//    - overflow=1 if the raw window count exceeded 99, else 0. Digits still saturate at 9/9.
//  FREQ_OVERFLOW_EN undefined:
//    - No overflow port or logic; the count saturates silently at 99.
// STRUCTURE
//  Package freq_counter_pkg contains:
//    - state encoding localparams ST_COUNT, ST_TENS, ST_LOAD
//    - BCD_MAX=99 and DIGIT_W=4
//  Sub-module edge_sync_detect (clk, reset, async_in -> edge_pulse) holds the synchroniser and edge detector.
//    It is shared with other input stages.
//  Remainder in this module: timer, edge counter, snapshot, FSM.
// TESTING (bench uses UPDATE_PERIOD=100 unless stated)
//  1 signal held low for 3 windows -> each window gives a load pulse with 0/0; load high exactly 1 cycle.
//  2 signal period 4 clk (25 edges/window) -> ten_count=2, unit_count=5 at load; digits stable between loads.
//  3 signal toggles every clk (50 edges) -> 5/0; load in cycle E+7. Check exact cycle against timer.
//  4 UPDATE_PERIOD=250, signal toggles every clk (125 edges) -> 9/9.
//    With FREQ_OVERFLOW_EN: overflow=1. Next window at period 20 clk -> overflow=0.
//  5 reset asserted during TENS of a 50-edge window -> no load pulse; outputs 0/0.
//    The first post-reset window reports only edges seen after reset release.
//  6 single edge placed so its pulse lands exactly in cycle E -> counted in the closing window (0/1).
//    The next empty window reports 0/0.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: FSM encoding and BCD constants shared by the frequency counter
package freq_counter_pkg;
   localparam int BCD_MAX = 99;
   localparam int DIGIT_W = 4;
   typedef enum logic [1:0] {
      ST_COUNT = 2'd0,
      ST_TENS  = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;
endpackage

// File: rtl/edge_sync_detect.sv
// edge_sync_detect: two-flop synchroniser followed by a registered rising-edge detector
// Ports: clk, reset (sync, active-high), async_in (raw pin),
//        edge_pulse (one-cycle pulse, 3 clk cycles after async_in rises)
module edge_sync_detect (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic edge_pulse
);
   logic [2:0] sync;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync       <= '0;
         edge_pulse <= 1'b0;
      end else begin
         sync       <= {sync[1:0], async_in};
         edge_pulse <= sync[1] & ~sync[2];
      end
   end
endmodule

// File: rtl/freq_edge_counter.sv
// freq_edge_counter: counts rising edges of an async input per gate window and reports them as two BCD digits
// Ports: clk, reset (sync, active-high), signal (async input), load (one-cycle digit strobe),
//        ten_count/unit_count (BCD digits, saturate at 99), overflow (only with FREQ_OVERFLOW_EN)
// Define FREQ_OVERFLOW_EN to add the overflow output flagging windows with more than 99 edges.
module freq_edge_counter
   import freq_counter_pkg::*;
#(
   parameter int UPDATE_PERIOD = 1200
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               signal,
   output logic               load,
   output logic [DIGIT_W-1:0] ten_count,
   output logic [DIGIT_W-1:0] unit_count
`ifdef FREQ_OVERFLOW_EN
   ,
   output logic               overflow
`endif
);
   localparam int EDGE_W  = $clog2(UPDATE_PERIOD + 1);
   localparam int TIMER_W = $clog2(UPDATE_PERIOD);
   localparam int WORK_W  = $clog2(BCD_MAX + 1);
   state_t state, state_next;
   logic [TIMER_W-1:0] timer;
   logic [EDGE_W-1:0]  edge_count, count_incl;
   logic [WORK_W-1:0]  work;
   logic [DIGIT_W-1:0] tens_acc;
   logic edge_pulse, window_end, over, take, done;
   edge_sync_detect u_sync (
      .clk(clk),
      .reset(reset),
      .async_in(signal),
      .edge_pulse(edge_pulse)
   );
   // a pulse landing in the window-end cycle still belongs to the closing window
   assign window_end = timer == TIMER_W'(UPDATE_PERIOD - 1);
   assign count_incl = edge_count + EDGE_W'(edge_pulse);
   assign over       = 32'(count_incl) > BCD_MAX;
   assign take       = state == ST_COUNT && window_end;
   assign done       = state == ST_TENS && work < WORK_W'(10);
   always_ff @(posedge clk) begin
      if (reset) state <= ST_COUNT;
      else       state <= state_next;
   end
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         ST_COUNT: state_next = window_end ? ST_TENS : ST_COUNT;
         ST_TENS:  state_next = done ? ST_LOAD : ST_TENS;
         ST_LOAD: begin
            load       = 1'b1;
            state_next = ST_COUNT;
         end
         default:  state_next = ST_COUNT;
      endcase
   end
   // conversion runs on the snapshot in work, so counting continues undisturbed
   always_ff @(posedge clk) begin
      if (reset) begin
         timer      <= '0;
         edge_count <= '0;
         work       <= '0;
         tens_acc   <= '0;
         ten_count  <= '0;
         unit_count <= '0;
      end else begin
         timer      <= window_end ? '0 : timer + TIMER_W'(1);
         edge_count <= window_end ? '0 : count_incl;
         if (take) begin
            work     <= over ? WORK_W'(BCD_MAX) : WORK_W'(count_incl);
            tens_acc <= '0;
         end else if (done) begin
            ten_count  <= tens_acc;
            unit_count <= work[DIGIT_W-1:0];
         end else if (state == ST_TENS) begin
            work     <= work - WORK_W'(10);
            tens_acc <= tens_acc + DIGIT_W'(1);
         end
      end
   end
`ifdef FREQ_OVERFLOW_EN
   logic over_snap;
   always_ff @(posedge clk) begin
      if (reset) begin
         over_snap <= 1'b0;
         overflow  <= 1'b0;
      end else if (take) begin
         over_snap <= over;
      end else if (done) begin
         overflow  <= over_snap;
      end
   end
`endif
endmodule
